// File: rtl/ddi_vc_link_endpoint.sv
// rtl/ddi_vc_link_endpoint.sv - multi-VC die-to-die link endpoint with credit flow control
// Credit-gated TX, parity-checked per-VC RX FIFOs, round-robin drain and credit return.
module ddi_vc_link_endpoint #(
  parameter int FLIT_WIDTH = 256,
  parameter int NUM_VC     = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int VCW = $clog2(NUM_VC),
  localparam int CW  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FLIT_WIDTH-1:0] tx_flit,
  input  logic [VCW-1:0]        tx_vc,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [FLIT_WIDTH-1:0] link_tx_flit,
  output logic [VCW-1:0]        link_tx_vc,
  output logic                  link_tx_par,
  output logic                  link_tx_valid,
  input  logic [NUM_VC-1:0]     link_credit_in,
  input  logic [FLIT_WIDTH-1:0] link_rx_flit,
  input  logic [VCW-1:0]        link_rx_vc,
  input  logic                  link_rx_par,
  input  logic                  link_rx_valid,
  output logic [NUM_VC-1:0]     link_credit_out,
  output logic [FLIT_WIDTH-1:0] rx_flit,
  output logic [VCW-1:0]        rx_vc,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [15:0]           par_err_cnt,
  output logic                  ovf_err,
  output logic                  crd_err
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [CW-1:0]         r_credit [NUM_VC];
  logic [CW-1:0]         r_pend   [NUM_VC];
  logic [CW-1:0]         r_cnt    [NUM_VC];
  logic [AW-1:0]         r_wptr   [NUM_VC];
  logic [AW-1:0]         r_rptr   [NUM_VC];
  logic [FLIT_WIDTH-1:0] r_mem    [NUM_VC][FIFO_DEPTH];
  logic [VCW-1:0]        r_rr;

  logic                  w_tx_fire;
  logic                  w_rx_par_ok;
  logic                  w_rx_full;
  logic                  w_rx_wr;
  logic                  w_par_drop;
  logic                  w_ovf;
  logic                  w_load;
  logic                  w_gnt_vld;
  logic [VCW-1:0]        w_gnt;
  logic [VCW-1:0]        w_cand;
  logic                  w_pop;
  logic [NUM_VC-1:0]     w_dec_v, w_wr_v, w_drop_v, w_pop_v, w_crd_hit;
  logic [CW:0]           w_csum, w_psum;
  logic [CW-1:0]         w_credit_nxt [NUM_VC];
  logic [CW-1:0]         w_pend_nxt   [NUM_VC];

  assign tx_ready    = (r_credit[tx_vc] != '0);
  assign w_tx_fire   = tx_valid && tx_ready;
  assign w_rx_par_ok = ((^link_rx_flit) == link_rx_par);
  assign w_rx_full   = (r_cnt[link_rx_vc] == CW'(FIFO_DEPTH));
  assign w_par_drop  = link_rx_valid && !w_rx_par_ok;
  assign w_ovf       = link_rx_valid && w_rx_par_ok && w_rx_full;
  assign w_rx_wr     = link_rx_valid && w_rx_par_ok && !w_rx_full;
  assign w_load      = !rx_valid || rx_ready;
  assign w_pop       = w_load && w_gnt_vld;

  // Arbiter sees only pre-edge counts, so a same-cycle write is invisible until next cycle.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    w_cand    = '0;
    for (int i = 1; i <= NUM_VC; i++) begin
      w_cand = VCW'((int'(r_rr) + i) % NUM_VC);
      if (!w_gnt_vld && (r_cnt[w_cand] != '0)) begin
        w_gnt_vld = 1'b1;
        w_gnt     = w_cand;
      end
    end
  end

  always_comb begin
    w_csum       = '0;
    w_psum       = '0;
    w_dec_v      = '0;
    w_wr_v       = '0;
    w_drop_v     = '0;
    w_pop_v      = '0;
    w_crd_hit    = '0;
    w_credit_nxt = '{default: '0};
    w_pend_nxt   = '{default: '0};
    for (int v = 0; v < NUM_VC; v++) begin
      w_dec_v[v]  = w_tx_fire && (tx_vc == VCW'(v));
      w_wr_v[v]   = w_rx_wr && (link_rx_vc == VCW'(v));
      w_drop_v[v] = w_par_drop && (link_rx_vc == VCW'(v));
      w_pop_v[v]  = w_pop && (w_gnt == VCW'(v));
      w_csum = {1'b0, r_credit[v]} + (CW + 1)'(link_credit_in[v]) - (CW + 1)'(w_dec_v[v]);
      w_crd_hit[v]    = (w_csum > DEPTH_W);
      w_credit_nxt[v] = w_crd_hit[v] ? CW'(FIFO_DEPTH) : w_csum[CW-1:0];
      // One credit leaves per cycle while new frees (drop + pop) may add two.
      w_psum = {1'b0, r_pend[v]} - (CW + 1)'(r_pend[v] != '0)
             + (CW + 1)'(w_drop_v[v]) + (CW + 1)'(w_pop_v[v]);
      w_pend_nxt[v] = (w_psum > DEPTH_W) ? CW'(FIFO_DEPTH) : w_psum[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_rx_wr) begin
      r_mem[link_rx_vc][r_wptr[link_rx_vc]] <= link_rx_flit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < NUM_VC; v++) begin
        r_credit[v] <= CW'(FIFO_DEPTH);
        r_pend[v]   <= '0;
        r_cnt[v]    <= '0;
        r_wptr[v]   <= '0;
        r_rptr[v]   <= '0;
      end
      r_rr            <= VCW'(NUM_VC - 1);
      link_tx_valid   <= 1'b0;
      link_tx_flit    <= '0;
      link_tx_vc      <= '0;
      link_tx_par     <= 1'b0;
      link_credit_out <= '0;
      rx_valid        <= 1'b0;
      rx_flit         <= '0;
      rx_vc           <= '0;
      par_err_cnt     <= '0;
      ovf_err         <= 1'b0;
      crd_err         <= 1'b0;
    end else begin
      link_tx_valid <= w_tx_fire;
      if (w_tx_fire) begin
        link_tx_flit <= tx_flit;
        link_tx_vc   <= tx_vc;
        link_tx_par  <= ^tx_flit;
      end
      for (int v = 0; v < NUM_VC; v++) begin
        r_credit[v]        <= w_credit_nxt[v];
        r_pend[v]          <= w_pend_nxt[v];
        link_credit_out[v] <= (r_pend[v] != '0);
        r_cnt[v]           <= r_cnt[v] + CW'(w_wr_v[v]) - CW'(w_pop_v[v]);
        if (w_wr_v[v])  r_wptr[v] <= r_wptr[v] + AW'(1);
        if (w_pop_v[v]) r_rptr[v] <= r_rptr[v] + AW'(1);
      end
      if (w_par_drop && (par_err_cnt != 16'hFFFF)) par_err_cnt <= par_err_cnt + 16'd1;
      if (w_ovf)       ovf_err <= 1'b1;
      if (|w_crd_hit)  crd_err <= 1'b1;
      if (w_load) begin
        rx_valid <= w_gnt_vld;
        if (w_gnt_vld) begin
          rx_flit <= r_mem[w_gnt][r_rptr[w_gnt]];
          rx_vc   <= w_gnt;
          r_rr    <= w_gnt;
        end
      end
    end
  end
endmodule

// File: doc/ddi_vc_link_endpoint.md
# ddi_vc_link_endpoint

Multi-virtual-channel die-to-die link endpoint with credit-based flow control, per-flit parity and per-VC receive buffering. It sits between a die's on-chip fabric and the D2D PHY adapter. It sends local flits onto the link only against credits granted by the far endpoint. It buffers received flits per VC, drains them to the fabric through a round-robin arbiter, and returns one credit per freed entry.

## Interface
- FLIT_WIDTH, 256, flit payload bits
- NUM_VC, 4, virtual channels (≥2); VCW = $clog2(NUM_VC)
- FIFO_DEPTH, 8, entries per VC receive FIFO; power of 2; also the initial TX credit count per VC
- CW = $clog2(FIFO_DEPTH+1), derived, credit/pending counter width

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- tx_flit  in  FLIT_WIDTH  local flit to send
- tx_vc  in  VCW  VC of tx_flit
- tx_valid  in  1  offer
- tx_ready  out  1  combinational: credit[tx_vc] != 0
- link_tx_flit  out  FLIT_WIDTH  registered flit to PHY
- link_tx_vc  out  VCW  registered VC
- link_tx_par  out  1  even parity (XOR) of link_tx_flit
- link_tx_valid  out  1  one-cycle strobe per flit
- link_credit_in  in  NUM_VC  bit v = one credit returned for VC v
- link_rx_flit  in  FLIT_WIDTH  flit from PHY
- link_rx_vc  in  VCW  its VC
- link_rx_par  in  1  its parity
- link_rx_valid  in  1  strobe, no backpressure
- link_credit_out  out  NUM_VC  bit v = one credit returned to far end for VC v
- rx_flit  out  FLIT_WIDTH  delivered flit
- rx_vc  out  VCW  its VC
- rx_valid  out  1  output stage holds a flit
- rx_ready  in  1  fabric accepts
- par_err_cnt  out  16  saturating count of dropped parity-error flits
- ovf_err  out  1  sticky: flit arrived for a full VC FIFO
- crd_err  out  1  sticky: credit return would exceed FIFO_DEPTH

## Operation
- Reset: credit[v] = FIFO_DEPTH; FIFOs empty; pending[v] = 0; RR pointer = NUM_VC-1; link_tx_valid, rx_valid, link_credit_out, ovf_err, crd_err = 0; par_err_cnt = 0; rx_flit, rx_vc, link_tx_* data = 0. Reset mid-operation discards all buffered flits and pending credits.
- TX: on tx_valid && tx_ready, register flit/vc/parity into link_tx_*, assert link_tx_valid next cycle, and decrement credit[tx_vc].
- Credit in: credit[v] += link_credit_in[v]. A same-cycle decrement and increment on one VC nets to 0. A result > FIFO_DEPTH clamps to FIFO_DEPTH and sets crd_err.
- RX write: on link_rx_valid, compute ^link_rx_flit.
  - Mismatch with link_rx_par: drop the flit, pending[vc]++, par_err_cnt++ (saturates at 0xFFFF).
  - Else, VC FIFO full: drop, set ovf_err, no credit returned.
  - Else: write the FIFO.
- RX drain: the output stage loads when empty or when rx_valid && rx_ready.
  - Arbiter grants the first non-empty VC searching from RR pointer+1 modulo NUM_VC. Pointer updates to the granted VC.
  - The pop increments pending[granted].
  - A flit written this cycle is not visible to the arbiter until the next cycle.
- Credit out: each cycle, for every v with pending[v] != 0 (pre-update value), assert link_credit_out[v] and decrement pending[v]. Pending from same-cycle events (parity drop and pop on one VC) accumulates. The counter never exceeds FIFO_DEPTH.
- FIFO pointers wrap modulo FIFO_DEPTH. Full/empty come from per-VC count (0..FIFO_DEPTH).

## Timing
- TX latency: handshake at edge N → link_tx_valid high in cycle N+1. Back-to-back sends on a VC are allowed while credit ≥ 1.
- tx_ready drops in the cycle after the last credit is consumed. A credit arriving at edge N makes tx_ready high in cycle N+1.
- RX latency: link_rx_valid at edge N into an empty endpoint → rx_valid in cycle N+2. Sustained throughput is 1 flit/cycle.
- Credit return: pop at edge N → link_credit_out bit high in cycle N+2 at the earliest. A parity drop behaves the same way.
- rx_flit and rx_vc are held stable while rx_valid && !rx_ready.

## Test plan
- Credit exhaustion: NUM_VC=4, FIFO_DEPTH=8; 9 back-to-back flits on VC2 with no credit_in → 8 link_tx_valid strobes; tx_ready=0 after the 8th. Pulse link_credit_in[2] → exactly one more flit sent.
- Round-robin: preload 2 flits each on VC0, VC1, VC3 with rx_ready=1 → delivery VC order 0,1,3,0,1,3. link_credit_out shows one pulse per pop on the matching bit.
- Backpressure: hold rx_ready=0 for 5 cycles with rx_valid=1 → rx_flit stable. The FIFO fills to 8; a 9th write sets ovf_err and no credit is returned.
- Parity error: inject a flit with flipped link_rx_par on VC1 → not delivered, par_err_cnt=1, link_credit_out[1] pulses once.
- Simultaneous events: parity drop and pop on VC0 in the same cycle → link_credit_out[0] high for 2 consecutive cycles. A credit_in and a send on one VC in the same cycle leave credit unchanged. Extra credit_in at credit=8 sets crd_err.
- Reset mid-traffic: assert rst with flits buffered → next cycle rx_valid=0, link_credit_out=0, all credits=8, and counters and sticky flags cleared.
